// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
// Shared VGA types and default 640x480@60Hz timing for the bar-pattern controller.
package vga_pkg;

  typedef logic [7:0] rgb332_t;  // RRRGGGBB

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic visible;
  } sync_t;

  localparam int CLK_DIV_DEF  = 4;

  localparam int H_VIS_DEF    = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int H_SYNC_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;

  localparam int V_VIS_DEF    = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int V_SYNC_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  localparam int BAR_WIDTH_DEF   = 80;
  localparam int SWAP_FRAMES_DEF = 60;

  localparam rgb332_t COLOUR_A_DEF = 8'hE0;
  localparam rgb332_t COLOUR_B_DEF = 8'h03;

  // Bits needed to hold a counter running 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_sig_gen.sv
`timescale 1ns/1ps
// Raster timing core: pixel-enable divider, horizontal/vertical counters and
// combinational sync/visible decode of the current counter values.
module vga_sig_gen #(
  parameter int CLK_DIV = vga_pkg::CLK_DIV_DEF,
  parameter int H_VIS   = vga_pkg::H_VIS_DEF,
  parameter int H_FP    = vga_pkg::H_FP_DEF,
  parameter int H_SYNC  = vga_pkg::H_SYNC_DEF,
  parameter int H_BP    = vga_pkg::H_BP_DEF,
  parameter int V_VIS   = vga_pkg::V_VIS_DEF,
  parameter int V_FP    = vga_pkg::V_FP_DEF,
  parameter int V_SYNC  = vga_pkg::V_SYNC_DEF,
  parameter int V_BP    = vga_pkg::V_BP_DEF,
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP,
  localparam int HW      = vga_pkg::cnt_width(H_TOTAL),
  localparam int VW      = vga_pkg::cnt_width(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           pe,
  output logic [HW-1:0]  hcount,
  output logic [VW-1:0]  vcount,
  output vga_pkg::sync_t sync
);
  import vga_pkg::*;

  localparam int DW   = cnt_width(CLK_DIV);
  localparam int H_SS = H_VIS + H_FP;
  localparam int H_SE = H_SS + H_SYNC - 1;
  localparam int V_SS = V_VIS + V_FP;
  localparam int V_SE = V_SS + V_SYNC - 1;

  logic [DW-1:0] div_reg, div_next;
  logic [HW-1:0] h_reg, h_next;
  logic [VW-1:0] v_reg, v_next;

  assign pe = (div_reg == DW'(CLK_DIV - 1));

  always_comb begin
    div_next = pe ? '0 : div_reg + DW'(1);
    h_next   = h_reg;
    v_next   = v_reg;
    if (pe) begin
      if (h_reg == HW'(H_TOTAL - 1)) begin
        h_next = '0;
        v_next = (v_reg == VW'(V_TOTAL - 1)) ? '0 : v_reg + VW'(1);
      end else begin
        h_next = h_reg + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
      h_reg   <= '0;
      v_reg   <= '0;
    end else begin
      div_reg <= div_next;
      h_reg   <= h_next;
      v_reg   <= v_next;
    end
  end

  always_comb begin
    sync.hs_n    = !((h_reg >= HW'(H_SS)) && (h_reg <= HW'(H_SE)));
    sync.vs_n    = !((v_reg >= VW'(V_SS)) && (v_reg <= VW'(V_SE)));
    sync.visible = (h_reg < HW'(H_VIS)) && (v_reg < VW'(V_VIS));
  end

  assign hcount = h_reg;
  assign vcount = v_reg;

endmodule

// File: rtl/vga_top.sv
`timescale 1ns/1ps
// VGA controller at the board pins: 640x480@60Hz sync plus red/blue vertical
// bars whose colours swap every SWAP_FRAMES frames.
module vga_top #(
  parameter int CLK_DIV     = vga_pkg::CLK_DIV_DEF,
  parameter int H_VIS       = vga_pkg::H_VIS_DEF,
  parameter int H_FP        = vga_pkg::H_FP_DEF,
  parameter int H_SYNC      = vga_pkg::H_SYNC_DEF,
  parameter int H_BP        = vga_pkg::H_BP_DEF,
  parameter int V_VIS       = vga_pkg::V_VIS_DEF,
  parameter int V_FP        = vga_pkg::V_FP_DEF,
  parameter int V_SYNC      = vga_pkg::V_SYNC_DEF,
  parameter int V_BP        = vga_pkg::V_BP_DEF,
  parameter int BAR_WIDTH   = vga_pkg::BAR_WIDTH_DEF,
  parameter int SWAP_FRAMES = vga_pkg::SWAP_FRAMES_DEF,
  parameter vga_pkg::rgb332_t COLOUR_A = vga_pkg::COLOUR_A_DEF,
  parameter vga_pkg::rgb332_t COLOUR_B = vga_pkg::COLOUR_B_DEF
) (
  input  logic       CLK_100MHz,
  input  logic       RESET,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [2:0] VGA_RED,
  output logic [2:0] VGA_GREEN,
  output logic [1:0] VGA_BLUE
);
  import vga_pkg::*;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);
  localparam int BW      = cnt_width(BAR_WIDTH);
  localparam int FW      = cnt_width(SWAP_FRAMES);

  logic          pe;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  sync_t         sync;

  vga_sig_gen #(
    .CLK_DIV(CLK_DIV),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_sig_gen (
    .clk    (CLK_100MHz),
    .rst_n  (RESET),
    .pe     (pe),
    .hcount (hcount),
    .vcount (vcount),
    .sync   (sync)
  );

  logic          line_end, frame_end;
  logic [BW-1:0] bar_px_reg, bar_px_next;
  logic          bar_odd_reg, bar_odd_next;
  logic [FW-1:0] frame_reg, frame_next;
  logic          swap_reg, swap_next;
  rgb332_t       colour_reg, colour_next;
  logic          hs_reg, vs_reg;

  assign line_end  = pe && (hcount == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (vcount == VW'(V_TOTAL - 1));

  // Bar parity is tracked incrementally alongside hcount instead of dividing
  // hcount by BAR_WIDTH; it always equals (hcount / BAR_WIDTH) bit 0.
  always_comb begin
    bar_px_next  = bar_px_reg;
    bar_odd_next = bar_odd_reg;
    frame_next   = frame_reg;
    swap_next    = swap_reg;
    if (line_end) begin
      bar_px_next  = '0;
      bar_odd_next = 1'b0;
    end else if (pe) begin
      if (bar_px_reg == BW'(BAR_WIDTH - 1)) begin
        bar_px_next  = '0;
        bar_odd_next = !bar_odd_reg;
      end else begin
        bar_px_next = bar_px_reg + BW'(1);
      end
    end
    if (frame_end) begin
      if (frame_reg == FW'(SWAP_FRAMES - 1)) begin
        frame_next = '0;
        swap_next  = !swap_reg;
      end else begin
        frame_next = frame_reg + FW'(1);
      end
    end
    colour_next = sync.visible ? ((bar_odd_reg ^ swap_reg) ? COLOUR_B : COLOUR_A) : 8'h00;
  end

  always_ff @(posedge CLK_100MHz or negedge RESET) begin
    if (!RESET) begin
      bar_px_reg  <= '0;
      bar_odd_reg <= 1'b0;
      frame_reg   <= '0;
      swap_reg    <= 1'b0;
      hs_reg      <= 1'b1;
      vs_reg      <= 1'b1;
      colour_reg  <= 8'h00;
    end else begin
      bar_px_reg  <= bar_px_next;
      bar_odd_reg <= bar_odd_next;
      frame_reg   <= frame_next;
      swap_reg    <= swap_next;
      if (pe) begin
        hs_reg     <= sync.hs_n;
        vs_reg     <= sync.vs_n;
        colour_reg <= colour_next;
      end
    end
  end

  assign VGA_HS    = hs_reg;
  assign VGA_VS    = vs_reg;
  assign VGA_RED   = colour_reg[7:5];
  assign VGA_GREEN = colour_reg[4:2];
  assign VGA_BLUE  = colour_reg[1:0];

endmodule

// File: tb/tb_vga_top.sv
`timescale 1ns/1ps
// Scoreboard bench: a full-size controller plus two shrunken geometries, all
// checked pixel by pixel against an arithmetic raster model.
module tb_vga_top;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } px_t;

  typedef struct {
    int hv, hfp, hsy, hbp;
    int vv, vfp, vsy, vbp;
    int bar, swap;
    logic [7:0] ca, cb;
  } geom_t;

  typedef struct {
    int  n;
    px_t f, a, b;
  } exp_t;

  localparam px_t IDLE = 10'b11_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       f_hs, f_vs, a_hs, a_vs, b_hs, b_vs;
  logic [2:0] f_r, f_g, a_r, a_g, b_r, b_g;
  logic [1:0] f_b, a_b, b_b;

  vga_top u_full (
    .CLK_100MHz(clk), .RESET(rst_n), .VGA_HS(f_hs), .VGA_VS(f_vs),
    .VGA_RED(f_r), .VGA_GREEN(f_g), .VGA_BLUE(f_b)
  );

  vga_top #(
    .H_VIS(40), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .BAR_WIDTH(8), .SWAP_FRAMES(1)
  ) u_swap1 (
    .CLK_100MHz(clk), .RESET(rst_n), .VGA_HS(a_hs), .VGA_VS(a_vs),
    .VGA_RED(a_r), .VGA_GREEN(a_g), .VGA_BLUE(a_b)
  );

  vga_top #(
    .H_VIS(24), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .BAR_WIDTH(5), .SWAP_FRAMES(3), .COLOUR_A(8'h1C), .COLOUR_B(8'hA5)
  ) u_odd (
    .CLK_100MHz(clk), .RESET(rst_n), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_RED(b_r), .VGA_GREEN(b_g), .VGA_BLUE(b_b)
  );

  px_t act_f, act_a, act_b;
  assign act_f = {f_hs, f_vs, f_r, f_g, f_b};
  assign act_a = {a_hs, a_vs, a_r, a_g, a_b};
  assign act_b = {b_hs, b_vs, b_r, b_g, b_b};

  geom_t geo [3];
  exp_t  sb_q [$];
  int    total = 0;
  int    bad   = 0;

  // Raster position, frame and swap state follow directly from the pixel index.
  function automatic px_t model(input geom_t g, input int n);
    int   ht, vt, h, line, v, frame;
    logic swapped;
    px_t  m;
    ht      = g.hv + g.hfp + g.hsy + g.hbp;
    vt      = g.vv + g.vfp + g.vsy + g.vbp;
    h       = n % ht;
    line    = n / ht;
    v       = line % vt;
    frame   = line / vt;
    swapped = ((frame / g.swap) % 2) == 1;
    m.hs    = !(h >= g.hv + g.hfp && h < g.hv + g.hfp + g.hsy);
    m.vs    = !(v >= g.vv + g.vfp && v < g.vv + g.vfp + g.vsy);
    m.rgb   = 8'h00;
    if (h < g.hv && v < g.vv)
      m.rgb = ((((h / g.bar) % 2) == 1) != swapped) ? g.cb : g.ca;
    return m;
  endfunction

  task automatic chk_px(input string name, input int n, input px_t act, input px_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s px=%0d got hs,vs,rgb=%b,%b,%02h required=%b,%b,%02h",
               name, n, act.hs, act.vs, act.rgb, req.hs, req.vs, req.rgb);
    end
  endtask

  task automatic chk_time(input string name, input time act, input time req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0t ns required=%0t ns", name, act, req);
    end
  endtask

  // Generator: every fourth clock after release the DUTs register a new pixel.
  int edge_cnt = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      edge_cnt = 0;
    end else begin
      exp_t e;
      edge_cnt++;
      if (edge_cnt % 4 == 0) begin
        e.n = edge_cnt / 4 - 1;
        e.f = model(geo[0], e.n);
        e.a = model(geo[1], e.n);
        e.b = model(geo[2], e.n);
        sb_q.push_back(e);
      end
    end
  end

  // Monitor: idle checks under reset, otherwise drain the scoreboard and time HS.
  time  t0 = 0, t_fall = 0;
  logic prev_hs = 1'b1, have_fall = 1'b0, first = 1'b0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      chk_px("idle_full", -1, act_f, IDLE);
      chk_px("idle_swap1", -1, act_a, IDLE);
      chk_px("idle_odd", -1, act_b, IDLE);
    end else begin
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk_px("pix_full", e.n, act_f, e.f);
        chk_px("pix_swap1", e.n, act_a, e.a);
        chk_px("pix_odd", e.n, act_b, e.b);
        if (e.n == 0) begin
          t0 = $time; prev_hs = 1'b1; have_fall = 1'b0; first = 1'b1;
        end
        if (prev_hs && !act_f.hs) begin
          if (first) chk_time("first_hs_fall", $time - t0, 26240);
          else if (have_fall) chk_time("hs_period", $time - t_fall, 32000);
          first = 1'b0; have_fall = 1'b1; t_fall = $time;
        end else if (!prev_hs && act_f.hs && have_fall) begin
          chk_time("hs_low", $time - t_fall, 3840);
        end
        prev_hs = act_f.hs;
      end
    end
  end

  initial begin
    geo[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 80, 60, 8'hE0, 8'h03};
    geo[1] = '{40, 4, 6, 4, 6, 2, 2, 2, 8, 1, 8'hE0, 8'h03};
    geo[2] = '{24, 2, 3, 3, 4, 1, 1, 2, 5, 3, 8'h1C, 8'hA5};
    rst_n = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6800) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(8000, 2000)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(4, 1));
      rst_n = 1'b0;
      repeat ($urandom_range(40, 3)) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (16000) @(posedge clk);
    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
